// File: rtl/pe_output_collector_if.sv
// PE result drain interface: the per-tile ready/data/taken handshake toward the
// PE array, plus the serialized valid/ready word stream toward writeback.
//
// Handshake semantics:
//   PE side  : pe_output_ready[i] high means pe_data[i] is a complete result and
//              stays stable until output_taken[i] pulses for one cycle.
//   Out side : a word transfers on every clock edge where out_valid && out_ready.
//              out_valid never depends on out_ready. out_ready with out_valid
//              low has no effect.
interface pe_output_collector_if #(
  parameter int IL         = 4,
  parameter int FL         = 16,
  parameter int tile       = 4,
  parameter int lanes      = 4,
  parameter int FIFO_DEPTH = 8
);
  localparam int W  = IL + FL;
  localparam int TW = $clog2(tile);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [tile-1:0]                   pe_output_ready;
  logic [tile-1:0][lanes-1:0][W-1:0] pe_data;
  logic [tile-1:0]                   output_taken;
  logic                              out_valid;
  logic                              out_ready;
  logic [W-1:0]                      out_data;
  logic [TW-1:0]                     out_tile;
  logic                              out_last;
  logic [CW-1:0]                     fifo_count;
  logic                              busy;
  logic                              state_dbg;   // 1 while the FSM is in SERIAL

  // Environment view: drives the PE results and the consumer's ready.
  modport master (
    output pe_output_ready, pe_data, out_ready,
    input  output_taken, out_valid, out_data, out_tile, out_last,
           fifo_count, busy, state_dbg
  );

  // Collector view.
  modport slave (
    input  pe_output_ready, pe_data, out_ready,
    output output_taken, out_valid, out_data, out_tile, out_last,
           fifo_count, busy, state_dbg
  );
endinterface

// File: rtl/pe_output_collector.sv
// Round-robin collector for per-tile PE result vectors. A granted vector is
// captured, acknowledged with a registered one-cycle output_taken pulse, and
// serialized lane by lane into a show-ahead FIFO that drives the output stream.
module pe_output_collector #(
  parameter int IL         = 4,
  parameter int FL         = 16,
  parameter int tile       = 4,
  parameter int lanes      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  pe_output_collector_if.slave    bus
);
  localparam int W  = IL + FL;
  localparam int TW = $clog2(tile);
  localparam int LW = (lanes > 1) ? $clog2(lanes) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE = 1'b0, SERIAL = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [TW-1:0]             rr_q, rr_d;
  logic [tile-1:0]           mask_q, mask_d;
  logic [lanes-1:0][W-1:0]   vec_q, vec_d;
  logic [TW-1:0]             g_q, g_d;
  logic [LW-1:0]             idx_q, idx_d;
  logic [tile-1:0]           taken_q, taken_d;

  logic [W-1:0]              mem_data_q [FIFO_DEPTH];
  logic [TW-1:0]             mem_tile_q [FIFO_DEPTH];
  logic                      mem_last_q [FIFO_DEPTH];
  logic [AW-1:0]             wr_q, rd_q;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic [tile-1:0]           eligible;
  logic                      grant_found;
  logic [TW-1:0]             grant_idx;
  logic [TW-1:0]             cand;
  logic                      fifo_full, fifo_empty;
  logic                      push, pop;
  logic                      push_last;

  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign pop        = !fifo_empty && bus.out_ready;
  assign push_last  = (idx_q == LW'(lanes - 1));

  // Round-robin search: first eligible tile starting at rr_q, wrapping mod tile.
  // The tile just served is masked for one IDLE cycle so a PE that has not yet
  // dropped its ready flag is not granted twice.
  always_comb begin
    eligible    = bus.pe_output_ready & ~mask_q;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < tile; k++) begin
      cand = TW'((int'(rr_q) + k) % tile);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // FSM next state: capture and acknowledge in IDLE, one lane per non-full cycle in SERIAL.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    mask_d  = mask_q;
    vec_d   = vec_q;
    g_d     = g_q;
    idx_d   = idx_q;
    taken_d = '0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        mask_d = '0;
        if (grant_found) begin
          vec_d              = bus.pe_data[grant_idx];
          g_d                = grant_idx;
          idx_d              = '0;
          taken_d[grant_idx] = 1'b1;
          state_d            = SERIAL;
        end
      end
      SERIAL: begin
        if (!fifo_full) begin
          push = 1'b1;
          if (push_last) begin
            state_d   = IDLE;
            rr_d      = (g_q == TW'(tile - 1)) ? '0 : g_q + 1'b1;
            mask_d    = '0;
            mask_d[g_q] = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      mask_q  <= '0;
      vec_q   <= '0;
      g_q     <= '0;
      idx_q   <= '0;
      taken_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      mask_q  <= mask_d;
      vec_q   <= vec_d;
      g_q     <= g_d;
      idx_q   <= idx_d;
      taken_q <= taken_d;
    end
  end

  // FIFO occupancy: push is already blocked when full, so a full FIFO only drains.
  always_comb begin
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO pointers and count; pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage; contents are only observable through occupied slots, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_q] <= vec_q[idx_q];
      mem_tile_q[wr_q] <= g_q;
      mem_last_q[wr_q] <= push_last;
    end
  end

  assign bus.output_taken = taken_q;
  assign bus.out_valid    = !fifo_empty;
  assign bus.out_data     = fifo_empty ? '0 : mem_data_q[rd_q];
  assign bus.out_tile     = fifo_empty ? '0 : mem_tile_q[rd_q];
  assign bus.out_last     = fifo_empty ? 1'b0 : mem_last_q[rd_q];
  assign bus.fifo_count   = cnt_q;
  assign bus.busy         = (state_q != IDLE) || !fifo_empty;
  assign bus.state_dbg    = (state_q == SERIAL);
endmodule
